// File: rtl/operand_frame_loader.sv
// Assembles 3-byte frames (command, operand A, operand B) from a valid/ready byte
// stream and issues one-cycle load enables to the downstream add/subtract registers.
module operand_frame_loader #(
  parameter int unsigned GAP   = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       d1,
  output logic [7:0]       d2,
  output logic             ld1,
  output logic             ld2,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, OPA, OPB, ISSUE, GAPW} state_t;

  // Reload value for the gap counter; GAPW lasts GAP cycles counting down to zero.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state, state_nxt;
  logic [1:0] cmd;
  logic [7:0] a_stage;
  logic [3:0] gap_cnt;
  logic       xfer;
  logic       take_cmd, take_a, take_b, bad_cmd;

  assign in_ready = (state == IDLE) || (state == OPA) || (state == OPB);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    take_cmd  = 1'b0;
    take_a    = 1'b0;
    take_b    = 1'b0;
    bad_cmd   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (in_data[1:0] == 2'b00) begin
            bad_cmd = 1'b1;
          end else begin
            take_cmd  = 1'b1;
            state_nxt = OPA;
          end
        end
      end
      OPA: begin
        if (xfer) begin
          take_a    = 1'b1;
          state_nxt = OPB;
        end
      end
      OPB: begin
        if (xfer) begin
          take_b    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = (GAP > 0) ? GAPW : IDLE;
      GAPW: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd       <= '0;
      a_stage   <= '0;
      gap_cnt   <= '0;
      d1        <= '0;
      d2        <= '0;
      ld1       <= 1'b0;
      ld2       <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      err   <= bad_cmd;
      // Load enables are derived from the accept edge, so they self-clear after ISSUE.
      ld1   <= take_b && cmd[0];
      ld2   <= take_b && cmd[1];
      if (take_cmd) cmd <= in_data[1:0];
      if (take_a)   a_stage <= in_data;
      if (take_b) begin
        d1        <= a_stage;
        d2        <= in_data;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (state == ISSUE) begin
        gap_cnt <= GAP_LAST;
      end else if ((state == GAPW) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule
